// File: rtl/count_capture_buffer_pkg.sv
// count_capture_buffer_pkg
// Shared definitions for the count capture buffer: FSM state encoding,
// default geometry and the counter value that marks a wrap.
package count_capture_buffer_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int DEPTH_DEF  = 16;
  localparam int ADDR_W_DEF = 4;

  // Encoding is visible on the state output, so values are fixed.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_POST  = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  // Last value of the free-running counter before it rolls over.
  localparam logic [DATA_W_DEF-1:0] WRAP_VALUE = '1;

endpackage

// File: rtl/count_capture_buffer_mem.sv
// capture_mem
// DEPTH x DATA_W register array with one write port and one registered
// read port. Contents are not reset; the owner tracks which entries are valid.
// Ports:
//   clk      clock
//   we_i     write enable
//   waddr_i  write address
//   wdata_i  write data
//   re_i     read enable; rdata_o updates on the next edge
//   raddr_i  read address
//   rdata_o  registered read data (held while re_i is low)
module capture_mem #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic              re_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
    if (re_i) begin
      rdata_q <= mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/count_capture_buffer.sv
// count_capture_buffer
// Captures a trigger-centred window of counter samples into a circular
// buffer, and counts counter wraps (samples equal to all-ones).
// Ports:
//   clk, rst           clock, synchronous active-high reset
//   in_valid, in_data  sample stream
//   arm                start / restart a capture (any state)
//   trig_value         value that triggers the capture
//   state, done        FSM state (0..3) and DONE flag
//   fill_cnt           entries written since arm, saturates at DEPTH
//   rd_en, rd_addr     read request, logical index (0 = oldest)
//   rd_data, rd_valid  read result, one cycle after rd_en
//   wrap_pulse         one-cycle pulse per all-ones sample
//   wrap_cnt           saturating count of all-ones samples
//
// Read handshake: rd_valid is asserted exactly one cycle after each cycle
// rd_en is high; there is no back-pressure, and rd_data is qualified only
// while rd_valid is high (it reads 0 otherwise).
module count_capture_buffer
  import count_capture_buffer_pkg::*;
#(
  parameter int DATA_W    = DATA_W_DEF,
  parameter int DEPTH     = DEPTH_DEF,
  parameter int ADDR_W    = ADDR_W_DEF,
  parameter int POST_TRIG = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  input  logic              arm,
  input  logic [DATA_W-1:0] trig_value,
  output logic [1:0]        state,
  output logic              done,
  output logic [ADDR_W:0]   fill_cnt,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              wrap_pulse,
  output logic [15:0]       wrap_cnt
);

  localparam logic [ADDR_W:0]   FILL_MAX  = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] POST_LOAD = ADDR_W'(POST_TRIG);
  localparam logic [DATA_W-1:0] WRAP_HIT  = '1;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] start_ptr_q, start_ptr_d;
  logic [ADDR_W:0]   fill_cnt_q, fill_cnt_d;
  logic [ADDR_W-1:0] post_cnt_q, post_cnt_d;
  logic              mem_we;
  logic              rd_hit, rd_hit_q;
  logic              rd_valid_q;
  logic [ADDR_W-1:0] rd_phys;
  logic [DATA_W-1:0] mem_rdata;
  logic              wrap_hit;
  logic              wrap_pulse_q;
  logic [15:0]       wrap_cnt_q;

  // ---------------------------------------------------------------------
  // Capture FSM next-state
  // ---------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    wr_ptr_d    = wr_ptr_q;
    start_ptr_d = start_ptr_q;
    fill_cnt_d  = fill_cnt_q;
    post_cnt_d  = post_cnt_q;
    mem_we      = 1'b0;

    if (arm) begin
      // Restart from any state; the sample in this cycle is dropped.
      state_d    = ST_ARMED;
      wr_ptr_d   = '0;
      fill_cnt_d = '0;
      post_cnt_d = '0;
    end else begin
      case (state_q)
        ST_ARMED: begin
          if (in_valid) begin
            mem_we     = 1'b1;
            wr_ptr_d   = wr_ptr_q + 1'b1;
            fill_cnt_d = (fill_cnt_q == FILL_MAX) ? fill_cnt_q : fill_cnt_q + 1'b1;
            if (in_data == trig_value) begin
              if (POST_TRIG == 0) begin
                state_d = ST_DONE;
              end else begin
                post_cnt_d = POST_LOAD;
                state_d    = ST_POST;
              end
            end
          end
        end
        ST_POST: begin
          if (in_valid) begin
            mem_we     = 1'b1;
            wr_ptr_d   = wr_ptr_q + 1'b1;
            fill_cnt_d = (fill_cnt_q == FILL_MAX) ? fill_cnt_q : fill_cnt_q + 1'b1;
            post_cnt_d = post_cnt_q - 1'b1;
            if (post_cnt_q == ADDR_W'(1)) begin
              state_d = ST_DONE;
            end
          end
        end
        default: ;
      endcase
    end

    // On entry to DONE the oldest entry is at wr_ptr once the buffer has
    // wrapped, otherwise at slot 0.
    if (state_d == ST_DONE && state_q != ST_DONE) begin
      start_ptr_d = (fill_cnt_d == FILL_MAX) ? wr_ptr_d : '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      wr_ptr_q    <= '0;
      start_ptr_q <= '0;
      fill_cnt_q  <= '0;
      post_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      start_ptr_q <= start_ptr_d;
      fill_cnt_q  <= fill_cnt_d;
      post_cnt_q  <= post_cnt_d;
    end
  end

  // ---------------------------------------------------------------------
  // Read port: logical index rotated by start_ptr into the circular buffer
  // ---------------------------------------------------------------------
  assign rd_phys = start_ptr_q + rd_addr;
  assign rd_hit  = (state_q == ST_DONE) && ({1'b0, rd_addr} < fill_cnt_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_valid_q <= 1'b0;
      rd_hit_q   <= 1'b0;
    end else begin
      rd_valid_q <= rd_en;
      rd_hit_q   <= rd_en && rd_hit;
    end
  end

  capture_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_mem (
    .clk     (clk),
    .we_i    (mem_we),
    .waddr_i (wr_ptr_q),
    .wdata_i (in_data),
    .re_i    (rd_en),
    .raddr_i (rd_phys),
    .rdata_o (mem_rdata)
  );

  // Misses and idle cycles read as zero; memory output is never exposed raw.
  assign rd_data  = rd_hit_q ? mem_rdata : '0;
  assign rd_valid = rd_valid_q;

  // ---------------------------------------------------------------------
  // Wrap detection, independent of the capture FSM
  // ---------------------------------------------------------------------
  assign wrap_hit = in_valid && (in_data == WRAP_HIT);

  always_ff @(posedge clk) begin
    if (rst) begin
      wrap_pulse_q <= 1'b0;
      wrap_cnt_q   <= '0;
    end else begin
      wrap_pulse_q <= wrap_hit;
      if (wrap_hit && (wrap_cnt_q != 16'hFFFF)) begin
        wrap_cnt_q <= wrap_cnt_q + 16'd1;
      end
    end
  end

  assign wrap_pulse = wrap_pulse_q;
  assign wrap_cnt   = wrap_cnt_q;
  assign state      = state_q;
  assign done       = (state_q == ST_DONE);
  assign fill_cnt   = fill_cnt_q;

endmodule

// File: tb/tb_count_capture_buffer.sv
// tb_count_capture_buffer
// Directed bench for count_capture_buffer (default parameters,
// POST_TRIG = 8). Inputs change 1 ns after the rising edge; outputs are
// sampled at the same point, i.e. after the edge has settled.
module tb_count_capture_buffer;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic [7:0] in_data;
  logic       arm;
  logic [7:0] trig_value;
  logic [1:0] state;
  logic       done;
  logic [4:0] fill_cnt;
  logic       rd_en;
  logic [3:0] rd_addr;
  logic [7:0] rd_data;
  logic       rd_valid;
  logic       wrap_pulse;
  logic [15:0] wrap_cnt;

  int n_checks = 0;
  int n_fails  = 0;
  int pulses;

  count_capture_buffer dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .arm        (arm),
    .trig_value (trig_value),
    .state      (state),
    .done       (done),
    .fill_cnt   (fill_cnt),
    .rd_en      (rd_en),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .rd_valid   (rd_valid),
    .wrap_pulse (wrap_pulse),
    .wrap_cnt   (wrap_cnt)
  );

  // clock
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock with the given stream inputs.
  task automatic step(input logic v, input logic [7:0] d, input logic a);
    in_valid = v;
    in_data  = d;
    arm      = a;
    @(posedge clk);
    #1;
  endtask

  // Logical read with a hand-computed expected value.
  task automatic rd_chk(input string tag, input logic [3:0] addr, input logic [7:0] exp);
    in_valid = 1'b0;
    arm      = 1'b0;
    rd_en    = 1'b1;
    rd_addr  = addr;
    @(posedge clk);
    #1;
    rd_en = 1'b0;
    chk({tag, "_valid"}, {31'd0, rd_valid}, 32'd1);
    chk(tag, {24'd0, rd_data}, {24'd0, exp});
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = '0; arm = 1'b0;
    trig_value = 8'd0; rd_en = 1'b0; rd_addr = '0;
    step(0, 0, 0);
    step(0, 0, 0);
    rst = 1'b0;

    // ---- reset values and idle stream ----
    chk("rst_state", state, 0);
    chk("rst_fill", fill_cnt, 0);
    chk("rst_rd_valid", rd_valid, 0);
    chk("rst_wrap_cnt", wrap_cnt, 0);
    chk("rst_wrap_pulse", wrap_pulse, 0);
    for (int i = 0; i < 20; i++) step(1, 8'(i), 0);
    chk("idle_state", state, 0);
    chk("idle_fill", fill_cnt, 0);
    rd_chk("idle_rd0", 4'd0, 8'd0);
    step(0, 0, 0);
    chk("idle_rd_valid_drop", rd_valid, 0);

    // ---- basic capture: trigger 100, window 93..108 ----
    trig_value = 8'd100;
    step(0, 0, 1);
    chk("arm_state", state, 1);
    chk("arm_fill", fill_cnt, 0);
    for (int i = 0; i <= 100; i++) step(1, 8'(i), 0);
    chk("trig_state_post", state, 2);
    for (int i = 101; i <= 107; i++) step(1, 8'(i), 0);
    chk("post_not_done", state, 2);
    step(1, 8'd108, 0);
    chk("basic_state_done", state, 3);
    chk("basic_done_flag", done, 1);
    chk("basic_fill", fill_cnt, 16);
    step(0, 0, 0);
    for (int i = 0; i < 16; i++) rd_chk("basic_rd", 4'(i), 8'(93 + i));

    // ---- short pre-trigger: trigger 3, window 0..11 ----
    trig_value = 8'd3;
    step(0, 0, 1);
    for (int i = 0; i <= 2; i++) step(1, 8'(i), 0);
    chk("short_fill_mid", fill_cnt, 3);
    for (int i = 3; i <= 11; i++) step(1, 8'(i), 0);
    chk("short_state", state, 3);
    chk("short_fill", fill_cnt, 12);
    for (int i = 0; i < 4; i++) step(1, 8'(200 + i), 0);
    chk("done_no_write_fill", fill_cnt, 12);
    chk("done_hold_state", state, 3);
    for (int i = 0; i < 16; i++) rd_chk("short_rd", 4'(i), (i < 12) ? 8'(i) : 8'd0);

    // ---- wrap detection ----
    pulses = 0;
    for (int i = 250; i <= 260; i++) begin
      step(1, 8'(i), 0);
      if (wrap_pulse) pulses++;
      if (i == 255) chk("wrap_pulse_at_255", wrap_pulse, 1);
      if (i == 256) chk("wrap_pulse_after", wrap_pulse, 0);
    end
    chk("wrap_pulse_count", pulses, 1);
    chk("wrap_cnt_1", wrap_cnt, 1);
    for (int i = 0; i < 256; i++) step(1, 8'(i), 0);
    chk("wrap_cnt_2", wrap_cnt, 2);
    step(1, 8'hFF, 0);
    chk("b2b_pulse_a", wrap_pulse, 1);
    step(1, 8'hFF, 0);
    chk("b2b_pulse_b", wrap_pulse, 1);
    step(0, 8'hFF, 0);
    chk("invalid_ff_no_pulse", wrap_pulse, 0);
    chk("wrap_cnt_4", wrap_cnt, 4);

    // ---- re-arm mid POST ----
    trig_value = 8'd50;
    step(0, 0, 1);
    for (int i = 0; i <= 52; i++) step(1, 8'(i), 0);
    chk("rearm_in_post", state, 2);
    trig_value = 8'd80;
    step(1, 8'd53, 1);
    chk("rearm_state", state, 1);
    chk("rearm_fill", fill_cnt, 0);
    for (int i = 54; i <= 88; i++) step(1, 8'(i), 0);
    chk("rearm_done", state, 3);
    chk("rearm_fill16", fill_cnt, 16);
    for (int i = 0; i < 16; i++) rd_chk("rearm_rd", 4'(i), 8'(73 + i));

    // ---- gaps during POST: window 13..28 ----
    trig_value = 8'd20;
    step(0, 0, 1);
    for (int i = 0; i <= 20; i++) step(1, 8'(i), 0);
    for (int i = 21; i <= 28; i++) begin
      step(1, 8'(i), 0);
      if (i == 27) chk("gap_post_7", state, 2);
      step(0, 8'd99, 0);
    end
    chk("gap_done", state, 3);
    chk("gap_fill", fill_cnt, 16);
    rd_chk("gap_rd0", 4'd0, 8'd13);
    rd_chk("gap_rd7", 4'd7, 8'd20);
    rd_chk("gap_rd15", 4'd15, 8'd28);

    // ---- reset during POST ----
    trig_value = 8'd5;
    step(0, 0, 1);
    for (int i = 0; i <= 6; i++) step(1, 8'(i), 0);
    chk("pre_rst_post", state, 2);
    rst = 1'b1;
    step(0, 0, 0);
    rst = 1'b0;
    chk("midrst_state", state, 0);
    chk("midrst_fill", fill_cnt, 0);
    chk("midrst_wrap_cnt", wrap_cnt, 0);
    rd_chk("midrst_rd", 4'd0, 8'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
